// File: rtl/result_wb_if.sv
// Bundles the signals between the ALU, the result writeback buffer, the
// register file and the operand-forwarding path.
// Ports: none. Modport master = ALU/regfile/decode side, slave = buffer.
interface result_wb_if;
    // ALU result offer
    logic        invalid;
    logic [31:0] resultin;
    logic [4:0]  destreg;
    logic        inready;
    // register-file write port
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic        wbready;
    // operand forwarding lookup
    logic [4:0]  srcreg1;
    logic [4:0]  srcreg2;
    logic        fwd1hit;
    logic        fwd2hit;
    logic [31:0] fwd1data;
    logic [31:0] fwd2data;
    // occupancy
    logic [3:0]  pendcount;

    modport master (
        output invalid, resultin, destreg, wbready, srcreg1, srcreg2,
        input  inready, regwrite, writereg, writedata,
        input  fwd1hit, fwd2hit, fwd1data, fwd2data, pendcount
    );

    modport slave (
        input  invalid, resultin, destreg, wbready, srcreg1, srcreg2,
        output inready, regwrite, writereg, writedata,
        output fwd1hit, fwd2hit, fwd1data, fwd2data, pendcount
    );
endinterface

// File: rtl/result_wb.sv
// Purpose: FIFO of ALU results awaiting register-file writeback, with operand forwarding.
// Latency: a result pushed into an empty buffer is offered on regwrite one cycle later.
// Backpressure: inready drops when full (never combinationally from wbready); head holds while wbready=0.
// Ports: clk, rst_n (async active-low), bus (result_wb_if.slave: ALU offer,
// register-file write, forwarding lookup, pendcount).
module result_wb #(
    parameter int DEPTH = 2    // power of two, 2..8
) (
    input  logic       clk,
    input  logic       rst_n,
    result_wb_if.slave bus
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_t;

    logic [4:0]    mem_reg [DEPTH];
    logic [31:0]   mem_dat [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [3:0]    count;
    logic [3:0]    count_nxt;
    occ_t          state;
    logic          push;
    logic          pop;

    // Occupancy state is a pure decode of count; count is the only state.
    always_comb begin
        state = PARTIAL;
        if (count == 4'd0) begin
            state = EMPTY;
        end else if (count == 4'(DEPTH)) begin
            state = FULL;
        end
    end

    // inready depends only on occupancy, so a full buffer refuses a new
    // result even in a cycle where the head is being written back.
    assign bus.inready = (state != FULL);
    assign bus.regwrite = (state != EMPTY);

    // Writes to r0 are accepted from the ALU but never stored.
    assign push = bus.invalid && bus.inready && (bus.destreg != 5'd0);
    assign pop  = bus.regwrite && bus.wbready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 4'd1;
            2'b01:   count_nxt = count - 4'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 4'd0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= 5'd0;
                mem_dat[i] <= 32'd0;
            end
        end else begin
            count <= count_nxt;
            if (push) begin
                mem_reg[wr_ptr] <= bus.destreg;
                mem_dat[wr_ptr] <= bus.resultin;
                // pointers are PW bits wide, so they wrap modulo DEPTH
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Popped slots keep stale contents, so the head is gated when empty.
    assign bus.writereg  = (state == EMPTY) ? 5'd0  : mem_reg[rd_ptr];
    assign bus.writedata = (state == EMPTY) ? 32'd0 : mem_dat[rd_ptr];
    assign bus.pendcount = count;

    // Forwarding walks the occupied entries oldest to youngest so the
    // youngest match is the one left standing. Only stored entries are
    // searched; a result being pushed this cycle shows up next cycle.
    logic [PW-1:0] idx;

    always_comb begin
        idx          = '0;
        bus.fwd1hit  = 1'b0;
        bus.fwd2hit  = 1'b0;
        bus.fwd1data = 32'd0;
        bus.fwd2data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (4'(i) < count) begin
                if ((bus.srcreg1 != 5'd0) && (mem_reg[idx] == bus.srcreg1)) begin
                    bus.fwd1hit  = 1'b1;
                    bus.fwd1data = mem_dat[idx];
                end
                if ((bus.srcreg2 != 5'd0) && (mem_reg[idx] == bus.srcreg2)) begin
                    bus.fwd2hit  = 1'b1;
                    bus.fwd2data = mem_dat[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_result_wb.sv
module tb_result_wb;

    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    result_wb_if bus ();

    result_wb #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        inv;
        logic [4:0]  d;
        logic [31:0] dat;
        logic        wb;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        e_rdy;
        logic [3:0]  e_pend;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] v;
    } ent_t;

    int checks   = 0;
    int failures = 0;

    // scoreboard: results accepted but not yet written back, oldest first
    ent_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] fwd_model(input logic [4:0] s);
        logic [32:0] r;
        r = 33'd0;
        if (s != 5'd0) begin
            foreach (mq[k]) begin
                if (mq[k].r == s) r = {1'b1, mq[k].v};
            end
        end
        return r;
    endfunction

    task automatic step(input vec_t v, input bit tbl_chk);
        logic [32:0] f1;
        logic [32:0] f2;
        logic        m_push;
        ent_t        e;
        ent_t        ne;
        @(negedge clk);
        bus.invalid  = v.inv;
        bus.destreg  = v.d;
        bus.resultin = v.dat;
        bus.wbready  = v.wb;
        bus.srcreg1  = v.s1;
        bus.srcreg2  = v.s2;
        #1;
        f1 = fwd_model(v.s1);
        f2 = fwd_model(v.s2);
        chk("inready",   32'(bus.inready),   32'(mq.size() < DEPTH));
        chk("pendcount", 32'(bus.pendcount), 32'(mq.size()));
        chk("regwrite",  32'(bus.regwrite),  32'(mq.size() > 0));
        chk("fwd1hit",   32'(bus.fwd1hit),   32'(f1[32]));
        chk("fwd1data",  bus.fwd1data,       f1[31:0]);
        chk("fwd2hit",   32'(bus.fwd2hit),   32'(f2[32]));
        chk("fwd2data",  bus.fwd2data,       f2[31:0]);
        if (tbl_chk) begin
            chk("tbl_inready",   32'(bus.inready),   32'(v.e_rdy));
            chk("tbl_pendcount", 32'(bus.pendcount), 32'(v.e_pend));
            chk("tbl_fwd1hit",   32'(bus.fwd1hit),   32'(v.e_h1));
            chk("tbl_fwd1data",  bus.fwd1data,       v.e_d1);
            chk("tbl_fwd2hit",   32'(bus.fwd2hit),   32'(v.e_h2));
            chk("tbl_fwd2data",  bus.fwd2data,       v.e_d2);
        end
        m_push = v.inv && (mq.size() < DEPTH) && (v.d != 5'd0);
        if (bus.regwrite) begin
            if (mq.size() == 0) begin
                chk("spurious_regwrite", 32'(bus.regwrite), 32'd0);
            end else begin
                if (v.wb) e = mq.pop_front();
                else      e = mq[0];
                chk("writereg",  32'(bus.writereg), 32'(e.r));
                chk("writedata", bus.writedata,     e.v);
            end
        end else begin
            chk("writereg_idle",  32'(bus.writereg), 32'd0);
            chk("writedata_idle", bus.writedata,     32'd0);
        end
        @(posedge clk);
        if (m_push) begin
            ne.r = v.d;
            ne.v = v.dat;
            mq.push_back(ne);
        end
    endtask

    function automatic vec_t mk(input logic inv, input logic [4:0] d, input logic [31:0] dat,
                                input logic wb, input logic [4:0] s1, input logic [4:0] s2);
        vec_t v;
        v = '{inv, d, dat, wb, s1, s2, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 32'd0};
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        //           inv d  dat            wb s1 s2  rdy pend h1 d1          h2 d2
        tbl[0]  = '{1, 1, 32'hA,        0, 0, 0, 1, 0, 0, 0,            0, 0};
        tbl[1]  = '{1, 2, 32'hB,        0, 0, 0, 1, 1, 0, 0,            0, 0};
        tbl[2]  = '{1, 3, 32'hC,        0, 1, 2, 0, 2, 1, 32'hA,        1, 32'hB};
        tbl[3]  = '{1, 3, 32'hC,        1, 0, 0, 0, 2, 0, 0,            0, 0};
        tbl[4]  = '{1, 3, 32'hC,        1, 0, 0, 1, 1, 0, 0,            0, 0};
        tbl[5]  = '{0, 0, 32'h0,        1, 3, 0, 1, 1, 1, 32'hC,        0, 0};
        tbl[6]  = '{0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0,            0, 0};
        tbl[7]  = '{1, 0, 32'hDEADBEEF, 1, 0, 0, 1, 0, 0, 0,            0, 0};
        tbl[8]  = '{0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0,            0, 0};
        tbl[9]  = '{1, 5, 32'hFFFF0000, 1, 0, 0, 1, 0, 0, 0,            0, 0};
        tbl[10] = '{0, 0, 32'h0,        1, 5, 0, 1, 1, 1, 32'hFFFF0000, 0, 0};
        tbl[11] = '{0, 0, 32'h0,        1, 5, 0, 1, 0, 0, 0,            0, 0};
        tbl[12] = '{1, 7, 32'h1,        0, 7, 0, 1, 0, 0, 0,            0, 0};
        tbl[13] = '{1, 7, 32'h2,        0, 7, 0, 1, 1, 1, 32'h1,        0, 0};
        tbl[14] = '{0, 0, 32'h0,        0, 7, 0, 0, 2, 1, 32'h2,        0, 0};
        tbl[15] = '{0, 0, 32'h0,        0, 0, 7, 0, 2, 0, 0,            1, 32'h2};

        bus.invalid  = 1'b0;
        bus.destreg  = 5'd0;
        bus.resultin = 32'd0;
        bus.wbready  = 1'b0;
        bus.srcreg1  = 5'd0;
        bus.srcreg2  = 5'd0;
        rst_n        = 1'b0;
        #1;
        chk("rst_inready",   32'(bus.inready),   32'd1);
        chk("rst_regwrite",  32'(bus.regwrite),  32'd0);
        chk("rst_pendcount", 32'(bus.pendcount), 32'd0);
        chk("rst_writedata", bus.writedata,      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i], 1'b1);
        end

        // two entries pending: reset mid-cycle, outputs must clear at once
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_regwrite",  32'(bus.regwrite),  32'd0);
        chk("midrst_writereg",  32'(bus.writereg),  32'd0);
        chk("midrst_writedata", bus.writedata,      32'd0);
        chk("midrst_pendcount", 32'(bus.pendcount), 32'd0);
        chk("midrst_inready",   32'(bus.inready),   32'd1);
        chk("midrst_fwd1hit",   32'(bus.fwd1hit),   32'd0);
        chk("midrst_fwd1data",  bus.fwd1data,       32'd0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(0, 0, 0, 1, 7, 0), 1'b0);
        chk("postrst_regwrite", 32'(bus.regwrite), 32'd0);
        step(mk(1, 9, 32'h99, 1, 0, 0), 1'b0);
        step(mk(0, 0, 0, 1, 9, 9), 1'b0);
        step(mk(0, 0, 0, 1, 0, 0), 1'b0);

        // random traffic with frequent r0 and duplicate destinations
        for (int n = 0; n < 300; n++) begin
            step(mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)),
                    5'($urandom_range(0, 6))), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
